// File: rtl/scramble_handler_n_pkg.sv
// scramble_handler_n_pkg: state encoding, LFSR taps and permutation helper shared by the scrambler
package scramble_handler_n_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCRAMBLE = 2'd1, PLAY = 2'd2, SOLVED = 2'd3} state_t;
  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int MAX_BUS = 128;
  function automatic logic is_identity(input logic [MAX_BUS-1:0] bus, input int n, input int w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++)
      if (((bus >> (i * w)) & ((MAX_BUS'(1) << w) - MAX_BUS'(1))) != MAX_BUS'(i)) ok = 1'b0;
    return ok;
  endfunction
endpackage

// File: rtl/scramble_handler_n_if.sv
// scramble_handler_n_if: player command inputs and slot/status outputs of the scrambler
interface scramble_handler_n_if #(parameter int NUM_SLOTS = 6, parameter int IDX_W = 3, parameter int MOVE_W = 8);
  logic                       start;
  logic                       change;
  logic [IDX_W-1:0]           pos_a;
  logic [IDX_W-1:0]           pos_b;
  logic [1:0]                 mode;
  logic [NUM_SLOTS*IDX_W-1:0] slots;
  logic                       is_correct;
  logic                       busy;
  logic [MOVE_W-1:0]          move_count;
  logic                       bad_move;
  modport master (output start, change, pos_a, pos_b, mode, input slots, is_correct, busy, move_count, bad_move);
  modport slave (input start, change, pos_a, pos_b, mode, output slots, is_correct, busy, move_count, bad_move);
endinterface

// File: rtl/scramble_lfsr.sv
// scramble_lfsr: free-running 16-bit Fibonacci LFSR, reloaded with SEED on active-low reset
module scramble_lfsr
  import scramble_handler_n_pkg::*;
#(parameter logic [15:0] SEED = 16'hACE1) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);
  always_ff @(posedge clk)
    if (!rst) lfsr <= SEED;
    else lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
endmodule

// File: rtl/scramble_handler_n.sv
// scramble_handler_n: permutation puzzle core - LFSR scramble, player swaps, solve detection
module scramble_handler_n
  import scramble_handler_n_pkg::*;
#(
  parameter int          NUM_SLOTS  = 6,
  parameter int          IDX_W      = 3,
  parameter int          BASE_SWAPS = 4,
  parameter int          MOVE_W     = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input logic clk,
  input logic rst,
  scramble_handler_n_if.slave bus
);
  localparam int SW = NUM_SLOTS * IDX_W;
  state_t            st, st_n;
  logic [SW-1:0]     sv, sn;
  logic [15:0]       lfsr, cnt, cnt_n;
  logic [IDX_W-1:0]  k, k_n, j;
  logic [MOVE_W-1:0] mc, mc_n;
  logic              start_q, change_q, bad, bad_n;
  logic              start_ev, change_ev, valid, unused;
  scramble_lfsr #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .lfsr(lfsr));
  assign start_ev  = bus.start & ~start_q;
  assign change_ev = bus.change & ~change_q;
  assign j         = lfsr[IDX_W-1:0];
  assign unused    = ^lfsr;
  assign valid     = int'(bus.pos_a) < NUM_SLOTS && int'(bus.pos_b) < NUM_SLOTS && bus.pos_a != bus.pos_b;
  always_comb begin
    st_n = st;
    sn = sv;
    cnt_n = cnt;
    k_n = k;
    mc_n = mc;
    bad_n = 1'b0;
    if (start_ev && st != SCRAMBLE) begin
      st_n = SCRAMBLE;
      cnt_n = 16'((BASE_SWAPS << bus.mode) - 1);
      k_n = '0;
      mc_n = '0;
    end else if (st == SCRAMBLE) begin
      if (int'(j) < NUM_SLOTS && j != k) begin
        sn[int'(k)*IDX_W +: IDX_W] = sv[int'(j)*IDX_W +: IDX_W];
        sn[int'(j)*IDX_W +: IDX_W] = sv[int'(k)*IDX_W +: IDX_W];
      end
      k_n = (int'(k) == NUM_SLOTS - 1) ? '0 : k + 1'b1;
      cnt_n = cnt - 1'b1;
      if (cnt == '0) begin
        st_n = PLAY;
        // a scramble that lands on identity is nudged so play never starts solved
        if (is_identity(MAX_BUS'(sn), NUM_SLOTS, IDX_W)) sn[2*IDX_W-1:0] = {IDX_W'(0), IDX_W'(1)};
      end
    end else if (st == PLAY && change_ev) begin
      if (valid) begin
        sn[int'(bus.pos_a)*IDX_W +: IDX_W] = sv[int'(bus.pos_b)*IDX_W +: IDX_W];
        sn[int'(bus.pos_b)*IDX_W +: IDX_W] = sv[int'(bus.pos_a)*IDX_W +: IDX_W];
        mc_n = &mc ? mc : mc + 1'b1;
        st_n = is_identity(MAX_BUS'(sn), NUM_SLOTS, IDX_W) ? SOLVED : PLAY;
      end else bad_n = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      st <= IDLE;
      cnt <= '0;
      k <= '0;
      mc <= '0;
      bad <= 1'b0;
      start_q <= 1'b0;
      change_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) sv[i*IDX_W +: IDX_W] <= IDX_W'(i);
    end else begin
      st <= st_n;
      sv <= sn;
      cnt <= cnt_n;
      k <= k_n;
      mc <= mc_n;
      bad <= bad_n;
      start_q <= bus.start;
      change_q <= bus.change;
    end
  assign bus.slots      = sv;
  assign bus.is_correct = st == SOLVED;
  assign bus.busy       = st == SCRAMBLE;
  assign bus.move_count = mc;
  assign bus.bad_move   = bad;
endmodule

// File: tb/tb_scramble_handler_n.sv
// tb_scramble_handler_n: scenario tasks plus random traffic checked against a behavioural puzzle model
module tb_scramble_handler_n;
  localparam int N = 6, W = 3, B = 4, MW = 8;
  localparam logic [N*W-1:0] ID = 18'o543210;
  logic clk = 1'b0, rst = 1'b0;
  int n_checks = 0, n_fail = 0;
  scramble_handler_n_if #(.NUM_SLOTS(N), .IDX_W(W), .MOVE_W(MW)) bus ();
  scramble_handler_n #(.NUM_SLOTS(N), .IDX_W(W), .BASE_SWAPS(B), .MOVE_W(MW), .SEED(16'hACE1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // behavioural model: 0 idle, 1 scramble, 2 play, 3 solved
  int m_st, m_rem, m_k, m_mc, m_lfsr;
  int m_s[N];
  bit m_bad, m_sq, m_cq;
  function automatic bit m_ident();
    for (int i = 0; i < N; i++) if (m_s[i] != i) return 1'b0;
    return 1'b1;
  endfunction
  function automatic void m_swap(int a, int b);
    int t;
    t = m_s[a]; m_s[a] = m_s[b]; m_s[b] = t;
  endfunction
  function automatic logic [N*W-1:0] m_flat();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(m_s[i]);
    return r;
  endfunction
  always @(posedge clk) begin
    bit sev, cev;
    int j, a, b;
    if (!rst) begin
      m_st = 0; m_rem = 0; m_k = 0; m_mc = 0; m_bad = 0; m_lfsr = 'hACE1; m_sq = 0; m_cq = 0;
      for (int i = 0; i < N; i++) m_s[i] = i;
    end else begin
      sev = bus.start && !m_sq;
      cev = bus.change && !m_cq;
      m_sq = bus.start; m_cq = bus.change; m_bad = 0;
      a = int'(bus.pos_a); b = int'(bus.pos_b);
      if (sev && m_st != 1) begin
        m_st = 1; m_rem = B << bus.mode; m_k = 0; m_mc = 0;
      end else if (m_st == 1) begin
        j = m_lfsr % 8;
        if (j < N && j != m_k) m_swap(m_k, j);
        m_k = (m_k + 1) % N;
        m_rem--;
        if (m_rem == 0) begin
          m_st = 2;
          if (m_ident()) m_swap(0, 1);
        end
      end else if (m_st == 2 && cev) begin
        if (a < N && b < N && a != b) begin
          m_swap(a, b);
          if (m_mc < 255) m_mc++;
          if (m_ident()) m_st = 3;
        end else m_bad = 1;
      end
      j = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
      m_lfsr = ((m_lfsr << 1) | j) & 'hFFFF;
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wait_busy_done(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin cyc++; tick(); end
  endtask
  task automatic test_reset();
    rst = 1'b0; bus.start = 0; bus.change = 0; bus.pos_a = 0; bus.pos_b = 0; bus.mode = 0;
    tick(); tick();
    n_checks++; if (bus.slots !== ID) begin n_fail++; $display("FAIL reset_slots: got %o want %o", bus.slots, ID); end
    n_checks++; if (bus.is_correct !== 1'b0) begin n_fail++; $display("FAIL reset_is_correct: got %b want 0", bus.is_correct); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.move_count !== 8'd0) begin n_fail++; $display("FAIL reset_move_count: got %0d want 0", bus.move_count); end
    n_checks++; if (bus.bad_move !== 1'b0) begin n_fail++; $display("FAIL reset_bad_move: got %b want 0", bus.bad_move); end
    rst = 1'b1;
    tick();
  endtask
  task automatic test_scramble(input logic [1:0] md);
    int cyc, seen;
    bus.mode = md; bus.start = 1; tick(); bus.start = 0;
    wait_busy_done(cyc);
    n_checks++; if (cyc != (B << md)) begin n_fail++; $display("FAIL scramble_busy_len m%0d: got %0d want %0d", md, cyc, B << md); end
    seen = 0;
    for (int i = 0; i < N; i++) seen |= 1 << int'(bus.slots[i*W +: W]);
    n_checks++; if (seen != 'h3F) begin n_fail++; $display("FAIL scramble_perm: got mask %h want 3f", seen); end
    n_checks++; if (bus.slots === ID) begin n_fail++; $display("FAIL scramble_not_identity: got %o want non-identity", bus.slots); end
    n_checks++; if (bus.slots !== m_flat()) begin n_fail++; $display("FAIL scramble_model: got %o want %o", bus.slots, m_flat()); end
  endtask
  task automatic test_invalid();
    logic [N*W-1:0] pre;
    logic [MW-1:0] pm;
    int pa[3] = '{2, 0, 7};
    int pb[3] = '{2, 7, 1};
    for (int t = 0; t < 3; t++) begin
      pre = bus.slots; pm = bus.move_count;
      bus.pos_a = W'(pa[t]); bus.pos_b = W'(pb[t]); bus.change = 1; tick(); bus.change = 0;
      n_checks++; if (bus.bad_move !== 1'b1) begin n_fail++; $display("FAIL invalid_bad %0d: got %b want 1", t, bus.bad_move); end
      n_checks++; if (bus.slots !== pre) begin n_fail++; $display("FAIL invalid_slots %0d: got %o want %o", t, bus.slots, pre); end
      n_checks++; if (bus.move_count !== pm) begin n_fail++; $display("FAIL invalid_moves %0d: got %0d want %0d", t, bus.move_count, pm); end
      tick();
      n_checks++; if (bus.bad_move !== 1'b0) begin n_fail++; $display("FAIL invalid_bad_pulse %0d: got %b want 0", t, bus.bad_move); end
    end
  endtask
  task automatic test_swap_hold();
    logic [N*W-1:0] pre, exp;
    logic [MW-1:0] pm;
    pre = bus.slots; pm = bus.move_count;
    bus.pos_a = 0; bus.pos_b = 1;
    repeat (2) begin bus.change = 1; tick(); bus.change = 0; tick(); end
    n_checks++; if (bus.slots !== m_flat()) begin n_fail++; $display("FAIL swap2_model: got %o want %o", bus.slots, m_flat()); end
    if (m_st == 2) begin
      n_checks++; if (bus.slots !== pre) begin n_fail++; $display("FAIL swap2_restore: got %o want %o", bus.slots, pre); end
      n_checks++; if (bus.move_count !== pm + 8'd2) begin n_fail++; $display("FAIL swap2_moves: got %0d want %0d", bus.move_count, pm + 8'd2); end
      pre = bus.slots; pm = bus.move_count;
      exp = pre; exp[2*W +: W] = pre[3*W +: W]; exp[3*W +: W] = pre[2*W +: W];
      bus.pos_a = 2; bus.pos_b = 3; bus.change = 1;
      repeat (5) tick();
      bus.change = 0; tick();
      n_checks++; if (bus.slots !== exp) begin n_fail++; $display("FAIL hold_slots: got %o want %o", bus.slots, exp); end
      n_checks++; if (bus.move_count !== pm + 8'd1) begin n_fail++; $display("FAIL hold_moves: got %0d want %0d", bus.move_count, pm + 8'd1); end
    end
  endtask
  task automatic test_solve();
    int cur[N];
    int n, p, cyc, t;
    bus.mode = 1; bus.start = 1; tick(); bus.start = 0;
    wait_busy_done(cyc);
    for (int i = 0; i < N; i++) cur[i] = int'(bus.slots[i*W +: W]);
    n = 0;
    for (int i = 0; i < N; i++) begin
      p = i;
      for (int q = 0; q < N; q++) if (cur[q] == i) p = q;
      if (p != i) begin
        bus.pos_a = W'(i); bus.pos_b = W'(p); bus.change = 1; tick(); bus.change = 0;
        t = cur[i]; cur[i] = cur[p]; cur[p] = t; n++;
        n_checks++; if (bus.is_correct !== (i >= N - 2 || bus.slots === ID)) begin
          n_fail++; $display("FAIL solve_is_correct step%0d: got %b want %b", n, bus.is_correct, bus.slots === ID);
        end
        tick();
      end
    end
    n_checks++; if (bus.slots !== ID) begin n_fail++; $display("FAIL solve_slots: got %o want %o", bus.slots, ID); end
    n_checks++; if (bus.is_correct !== 1'b1) begin n_fail++; $display("FAIL solve_correct: got %b want 1", bus.is_correct); end
    n_checks++; if (bus.move_count !== 8'(n)) begin n_fail++; $display("FAIL solve_moves: got %0d want %0d", bus.move_count, n); end
    bus.pos_a = 0; bus.pos_b = 1; bus.change = 1; tick(); bus.change = 0;
    n_checks++; if (bus.slots !== ID) begin n_fail++; $display("FAIL post_solve_slots: got %o want %o", bus.slots, ID); end
    n_checks++; if (bus.bad_move !== 1'b0) begin n_fail++; $display("FAIL post_solve_bad: got %b want 0", bus.bad_move); end
    n_checks++; if (bus.move_count !== 8'(n)) begin n_fail++; $display("FAIL post_solve_moves: got %0d want %0d", bus.move_count, n); end
    tick();
  endtask
  task automatic test_precedence();
    logic [N*W-1:0] pre;
    int cyc;
    test_scramble(2'd0);
    pre = bus.slots;
    bus.pos_a = 0; bus.pos_b = 1; bus.start = 1; bus.change = 1; tick(); bus.start = 0; bus.change = 0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL prec_busy: got %b want 1", bus.busy); end
    n_checks++; if (bus.move_count !== 8'd0) begin n_fail++; $display("FAIL prec_moves: got %0d want 0", bus.move_count); end
    n_checks++; if (bus.slots !== pre) begin n_fail++; $display("FAIL prec_slots: got %o want %o", bus.slots, pre); end
    wait_busy_done(cyc);
  endtask
  task automatic test_mid_reset();
    bus.mode = 2; bus.start = 1; tick(); bus.start = 0;
    repeat (3) tick();
    rst = 1'b0; tick();
    n_checks++; if (bus.slots !== ID) begin n_fail++; $display("FAIL midrst_slots: got %o want %o", bus.slots, ID); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.move_count !== 8'd0) begin n_fail++; $display("FAIL midrst_moves: got %0d want 0", bus.move_count); end
    n_checks++; if (bus.is_correct !== 1'b0) begin n_fail++; $display("FAIL midrst_correct: got %b want 0", bus.is_correct); end
    rst = 1'b1; tick();
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      bus.start = ($urandom_range(0, 15) == 0);
      bus.change = ($urandom_range(0, 2) == 0);
      bus.pos_a = W'($urandom_range(0, 7));
      bus.pos_b = W'($urandom_range(0, 7));
      bus.mode = 2'($urandom_range(0, 3));
      tick();
      n_checks++; if (bus.slots !== m_flat()) begin n_fail++; $display("FAIL rand_slots c%0d: got %o want %o", c, bus.slots, m_flat()); end
      n_checks++; if (bus.busy !== (m_st == 1)) begin n_fail++; $display("FAIL rand_busy c%0d: got %b want %b", c, bus.busy, m_st == 1); end
      n_checks++; if (bus.is_correct !== (m_st == 3)) begin n_fail++; $display("FAIL rand_correct c%0d: got %b want %b", c, bus.is_correct, m_st == 3); end
      n_checks++; if (bus.move_count !== 8'(m_mc)) begin n_fail++; $display("FAIL rand_moves c%0d: got %0d want %0d", c, bus.move_count, m_mc); end
      n_checks++; if (bus.bad_move !== m_bad) begin n_fail++; $display("FAIL rand_bad c%0d: got %b want %b", c, bus.bad_move, m_bad); end
    end
    rst = 1'b1; bus.start = 0; bus.change = 0; tick();
  endtask
  initial begin
    tick();
    test_reset();
    test_scramble(2'd0);
    test_invalid();
    test_swap_hold();
    test_scramble(2'd3);
    test_solve();
    test_precedence();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
